// File: rtl/autoscale_pkg.sv
// Shared helpers for the autoscale_mc block normaliser: shift-width
// derivation, shift clamping and the saturation rail values.
package autoscale_pkg;

    // Width of the shift_value field for a given sample width.
    function automatic int shift_w(input int din_width);
        return $clog2(din_width);
    endfunction

    // Clamp a signed raw shift into [lo, hi].
    function automatic int clamp_shift(input int raw, input int lo, input int hi);
        if (raw < lo) begin
            return lo;
        end
        if (raw > hi) begin
            return hi;
        end
        return raw;
    endfunction

    // Most positive two's-complement value of a w-bit sample (MAXPOS).
    function automatic logic [63:0] sat_maxpos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit sample (MAXNEG).
    function automatic logic [63:0] sat_maxneg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/autoscale_mc_if.sv
// Streaming bus of autoscale_mc: input beats, output beats and the
// shift/end-of-frame side information travelling with each output beat.
interface autoscale_mc_if
    import autoscale_pkg::*;
#(
    parameter int DIN_WIDTH = 16,
    parameter int NCH       = 2
);
    localparam int SHIFT_W = shift_w(DIN_WIDTH);

    logic [NCH*DIN_WIDTH-1:0] din;
    logic                     din_valid;
    logic                     din_ready;
    logic [NCH*DIN_WIDTH-1:0] dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [SHIFT_W-1:0]       shift_value;
    logic                     dout_eof;

    modport master (
        output din, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, shift_value, dout_eof
    );

    modport slave (
        input  din, din_valid, dout_ready,
        output din_ready, dout, dout_valid, shift_value, dout_eof
    );

endinterface

// File: rtl/msb_position_enc.sv
// Registered priority encoder: index of the highest set bit of m, plus a
// flag when m is all zeros. Forms the second pipeline stage of autoscale_mc.
module msb_position_enc #(
    parameter int M_W = 15,
    parameter int P_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [M_W-1:0] m,
    output logic [P_W-1:0] p,
    output logic           zero
);

    logic [P_W-1:0] p_c;
    logic           zero_c;

    // Scan upward so the highest set bit wins.
    always_comb begin
        p_c    = '0;
        zero_c = ~|m;
        for (int i = 0; i < M_W; i++) begin
            if (m[i]) begin
                p_c = P_W'(i);
            end
        end
    end

    // Stage register, stalls with the rest of the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p    <= '0;
            zero <= 1'b0;
        end else if (en) begin
            p    <= p_c;
            zero <= zero_c;
        end
    end

endmodule

// File: rtl/autoscale_mc.sv
// autoscale_mc: multi-channel signed block normaliser in front of the
// CORDIC vectoring core. Finds the common headroom of NCH samples, shifts
// all channels left by one clamped amount and reports that amount.
// Per-sample or per-frame shift selection, ready/valid backpressure.
// Optional build macro AUTOSCALE_SAT_EN: saturate channels that overflow
// the applied shift instead of wrapping.
module autoscale_mc
    import autoscale_pkg::*;
#(
    parameter int DIN_WIDTH = 16,
    parameter int NCH       = 2,
    parameter int MAX_SHIFT = 10,
    parameter int MIN_SHIFT = 0,
    parameter int GUARD     = 1,
    parameter int FRAME_LEN = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_mode,
    autoscale_mc_if.slave  bus
);

    localparam int SHIFT_W = shift_w(DIN_WIDTH);
    localparam int CNT_W   = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int DW      = NCH * DIN_WIDTH;

`ifdef AUTOSCALE_SAT_EN
    localparam logic signed [DIN_WIDTH-1:0] MAXPOS = DIN_WIDTH'(sat_maxpos(DIN_WIDTH));
    localparam logic signed [DIN_WIDTH-1:0] MAXNEG = DIN_WIDTH'(sat_maxneg(DIN_WIDTH));
`endif

    // Bits where the sample differs from its upper neighbour; the highest
    // one marks the end of the redundant sign run.
    function automatic logic [DIN_WIDTH-2:0] sign_change(input logic [DIN_WIDTH-1:0] x);
        return x[DIN_WIDTH-2:0] ^ x[DIN_WIDTH-1:1];
    endfunction

    // Left shift by s; with saturation built, an overflowing sample is
    // replaced by the rail matching its sign.
    function automatic logic signed [DIN_WIDTH-1:0] shift_ch(
        input logic signed [DIN_WIDTH-1:0] x,
        input logic        [SHIFT_W-1:0]   s
    );
        logic signed [DIN_WIDTH-1:0] y;
        y = x <<< s;
`ifdef AUTOSCALE_SAT_EN
        if ((y >>> s) != x) begin
            y = x[DIN_WIDTH-1] ? MAXNEG : MAXPOS;
        end
`endif
        return y;
    endfunction

    logic                 en;
    logic [DIN_WIDTH-2:0] m_c;
    logic [DW-1:0]        x_p1, x_p2, x_p3;
    logic [DIN_WIDTH-2:0] m_p1;
    logic                 vld_p1, vld_p2, vld_p3;
    logic [SHIFT_W-1:0]   p_p2;
    logic                 zero_p2;
    logic [SHIFT_W-1:0]   s_p3;
    logic                 eof_p3;
    int                   raw_c;
    logic [SHIFT_W-1:0]   s_calc, s_use;
    logic                 mode_eff, frm_last, eof_c;
    logic [CNT_W-1:0]     frm_cnt, cnt_nxt;
    logic                 frm_mode_q;
    logic [SHIFT_W-1:0]   frm_shift_q;
    logic [DW-1:0]        dout_c;

    assign en            = bus.dout_ready | ~bus.dout_valid;
    assign bus.din_ready = en;

    // ---- Stage 1: sign-change mask OR-ed over all channels ----
    // Common mask: its top bit bounds the headroom of every channel.
    always_comb begin
        m_c = '0;
        for (int k = 0; k < NCH; k++) begin
            m_c = m_c | sign_change(bus.din[k*DIN_WIDTH +: DIN_WIDTH]);
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p1   <= '0;
            m_p1   <= '0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            x_p1   <= bus.din;
            m_p1   <= m_c;
            vld_p1 <= bus.din_valid;
        end
    end

    // ---- Stage 2: position of the highest mask bit ----
    msb_position_enc #(
        .M_W (DIN_WIDTH - 1),
        .P_W (SHIFT_W)
    ) u_enc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .m     (m_p1),
        .p     (p_p2),
        .zero  (zero_p2)
    );

    // Data and valid travelling alongside the encoder stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p2   <= '0;
            vld_p2 <= 1'b0;
        end else if (en) begin
            x_p2   <= x_p1;
            vld_p2 <= vld_p1;
        end
    end

    // ---- Stage 3: shift computation and frame selection ----
    // Fresh clamped shift, plus reuse of the latched frame shift inside a frame.
    always_comb begin
        raw_c    = (DIN_WIDTH - 2) - int'(p_p2) - GUARD;
        s_calc   = zero_p2 ? SHIFT_W'(MAX_SHIFT)
                           : SHIFT_W'(clamp_shift(raw_c, MIN_SHIFT, MAX_SHIFT));
        mode_eff = (frm_cnt == '0) ? frame_mode : frm_mode_q;
        frm_last = (frm_cnt == CNT_W'(FRAME_LEN - 1));
        s_use    = (mode_eff && (frm_cnt != '0)) ? frm_shift_q : s_calc;
        eof_c    = ~mode_eff | frm_last;
        cnt_nxt  = eof_c ? '0 : frm_cnt + 1'b1;
    end

    // Frame counter and frame-start latches; mode changes only land at count 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frm_cnt     <= '0;
            frm_mode_q  <= 1'b0;
            frm_shift_q <= '0;
        end else if (en && vld_p2) begin
            frm_cnt <= cnt_nxt;
            if (frm_cnt == '0) begin
                frm_mode_q  <= frame_mode;
                frm_shift_q <= s_calc;
            end
        end
    end

    // Stage 3 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_p3   <= '0;
            s_p3   <= '0;
            eof_p3 <= 1'b0;
            vld_p3 <= 1'b0;
        end else if (en) begin
            x_p3   <= x_p2;
            s_p3   <= s_use;
            eof_p3 <= eof_c;
            vld_p3 <= vld_p2;
        end
    end

    // ---- Stage 4: apply the shift to every channel ----
    // Same shift for all channels; shift_value is exactly what was applied.
    always_comb begin
        dout_c = '0;
        for (int k = 0; k < NCH; k++) begin
            dout_c[k*DIN_WIDTH +: DIN_WIDTH] = shift_ch(x_p3[k*DIN_WIDTH +: DIN_WIDTH], s_p3);
        end
    end

    // Output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout        <= '0;
            bus.shift_value <= '0;
            bus.dout_eof    <= 1'b0;
            bus.dout_valid  <= 1'b0;
        end else if (en) begin
            bus.dout        <= dout_c;
            bus.shift_value <= s_p3;
            bus.dout_eof    <= eof_p3;
            bus.dout_valid  <= vld_p3;
        end
    end

endmodule

// File: tb/tb_autoscale_mc.sv
// Bench for autoscale_mc: three instances (defaults, MIN_SHIFT=2,
// FRAME_LEN=4) share one input stream; each has its own expectations.
module tb_autoscale_mc;

`ifdef AUTOSCALE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef logic [36:0] rec_t;   // {eof, shift[3:0], dout[31:0]}

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
        logic [3:0]  sh;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_mode;
    logic [31:0] din;
    logic        din_valid;
    logic        dout_ready;

    int n_checks = 0;
    int n_fail   = 0;

    rec_t exq [3][$];
    int   mcnt   [3];
    int   mshift [3];
    logic mmode  [3];
    int   minsh  [3] = '{0, 2, 0};
    int   flen   [3] = '{8, 8, 4};

    autoscale_mc_if #(.DIN_WIDTH(16), .NCH(2)) if0 ();
    autoscale_mc_if #(.DIN_WIDTH(16), .NCH(2)) if1 ();
    autoscale_mc_if #(.DIN_WIDTH(16), .NCH(2)) if2 ();

    assign if0.din = din;  assign if0.din_valid = din_valid;  assign if0.dout_ready = dout_ready;
    assign if1.din = din;  assign if1.din_valid = din_valid;  assign if1.dout_ready = dout_ready;
    assign if2.din = din;  assign if2.din_valid = din_valid;  assign if2.dout_ready = dout_ready;

    autoscale_mc u_dut0 (.clk(clk), .rst_n(rst_n), .frame_mode(frame_mode), .bus(if0));
    autoscale_mc #(.MIN_SHIFT(2)) u_dut1 (.clk(clk), .rst_n(rst_n), .frame_mode(frame_mode), .bus(if1));
    autoscale_mc #(.FRAME_LEN(4)) u_dut2 (.clk(clk), .rst_n(rst_n), .frame_mode(frame_mode), .bus(if2));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Redundant sign bits below the MSB (15 for 0 and -1).
    function automatic int hr(input logic [15:0] x);
        int h = 0;
        for (int i = 14; i >= 0; i--) begin
            if (x[i] != x[15]) break;
            h++;
        end
        return h;
    endfunction

    function automatic logic [15:0] apply(input logic [15:0] x, input int s);
        logic [15:0] y;
        y = x << s;
        if (SAT && (s > hr(x))) y = x[15] ? 16'h8000 : 16'h7FFF;
        return y;
    endfunction

    task automatic model_push(input int d, input logic [31:0] x, input logic fm);
        int h, s, sf;
        logic meff, eof;
        h = hr(x[15:0]);
        if (hr(x[31:16]) < h) h = hr(x[31:16]);
        sf = (h == 15) ? 10 : h - 1;
        if (sf < minsh[d]) sf = minsh[d];
        if (sf > 10) sf = 10;
        meff = (mcnt[d] == 0) ? fm : mmode[d];
        s = (meff && mcnt[d] != 0) ? mshift[d] : sf;
        if (mcnt[d] == 0) begin
            mmode[d]  = fm;
            mshift[d] = sf;
        end
        eof = !meff || (mcnt[d] == flen[d] - 1);
        mcnt[d] = eof ? 0 : mcnt[d] + 1;
        exq[d].push_back({eof, 4'(s), apply(x[31:16], s), apply(x[15:0], s)});
    endtask

    function automatic rec_t dut_rec(input int d);
        case (d)
            0:       return {if0.dout_eof, if0.shift_value, if0.dout};
            1:       return {if1.dout_eof, if1.shift_value, if1.dout};
            default: return {if2.dout_eof, if2.shift_value, if2.dout};
        endcase
    endfunction

    function automatic logic dut_valid(input int d);
        case (d)
            0:       return if0.dout_valid;
            1:       return if1.dout_valid;
            default: return if2.dout_valid;
        endcase
    endfunction

    function automatic logic dut_ready(input int d);
        case (d)
            0:       return if0.din_ready;
            1:       return if1.din_ready;
            default: return if2.din_ready;
        endcase
    endfunction

    function automatic logic [31:0] rand_word();
        logic signed [15:0] a, b;
        a = 16'($urandom);
        b = 16'($urandom);
        a = a >>> $urandom_range(0, 15);
        b = b >>> $urandom_range(0, 15);
        return {a, b};
    endfunction

    // Called at a falling edge with dout_ready high; accepts on the next rising edge.
    task automatic send(input logic [31:0] x);
        din       = x;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int lat);
        lat = 0;
        while (!dut_valid(d) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_random(input int nbeats, input logic fm);
        int   sent = 0;
        int   cyc  = 0;
        bit   acc  = 0;
        rec_t e;
        frame_mode = fm;
        while ((sent < nbeats || (exq[0].size() + exq[1].size() + exq[2].size()) != 0) && cyc < 20000) begin
            if (acc) din_valid = 1'b0;
            acc = 0;
            dout_ready = ($urandom_range(0, 1) == 1);
            if (!din_valid && sent < nbeats && $urandom_range(0, 3) != 0) begin
                din       = rand_word();
                din_valid = 1'b1;
            end
            #1;
            for (int d = 0; d < 3; d++) begin
                check($sformatf("din_ready_dut%0d", d), 64'(dut_ready(d)),
                      64'(!(dut_valid(d) && !dout_ready)));
                if (dut_valid(d) && dout_ready) begin
                    if (exq[d].size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL rand_extra_dut%0d: actual %0h required none", d, dut_rec(d));
                    end else begin
                        e = exq[d].pop_front();
                        check($sformatf("rand_dut%0d", d), 64'(dut_rec(d)), 64'(e));
                    end
                end
            end
            if (din_valid && if0.din_ready) begin
                for (int d = 0; d < 3; d++) model_push(d, din, fm);
                sent++;
                acc = 1;
            end
            @(negedge clk);
            cyc++;
        end
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rand_leftover_dut%0d", d), 64'(exq[d].size()), 64'd0);
        end
    endtask

    initial begin
        vec_t        tbl [12];
        logic [31:0] f_din [4];
        logic [31:0] f_dout [4];
        logic        f_eof [4];
        int          lat;

        tbl[0]  = '{32'h0010FFF0, 32'h2000E000, 4'd9};
        tbl[1]  = '{32'h0000FFFF, 32'h0000FC00, 4'd10};
        tbl[2]  = '{32'h7FFF0000, 32'h7FFF0000, 4'd0};
        tbl[3]  = '{32'h80000001, 32'h80000001, 4'd0};
        tbl[4]  = '{32'h00010001, 32'h04000400, 4'd10};
        tbl[5]  = '{32'hFFFE0003, 32'hF8000C00, 4'd10};
        tbl[6]  = '{32'h08000000, 32'h20000000, 4'd2};
        tbl[7]  = '{32'hC0000000, 32'hC0000000, 4'd0};
        tbl[8]  = '{32'hE0000000, 32'hC0000000, 4'd1};
        tbl[9]  = '{32'h00000000, 32'h00000000, 4'd10};
        tbl[10] = '{32'hFFFFFFFF, 32'hFC00FC00, 4'd10};
        tbl[11] = '{32'h0040FF80, 32'h2000C000, 4'd7};

        f_din[0] = 32'h00100000; f_dout[0] = 32'h20000000;                          f_eof[0] = 1'b0;
        f_din[1] = 32'h01000000; f_dout[1] = SAT ? 32'h7FFF0000 : 32'h00000000;     f_eof[1] = 1'b0;
        f_din[2] = 32'h00100000; f_dout[2] = 32'h20000000;                          f_eof[2] = 1'b0;
        f_din[3] = 32'h00010000; f_dout[3] = 32'h02000000;                          f_eof[3] = 1'b1;

        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0; mshift[d] = 0; mmode[d] = 1'b0;
        end

        rst_n = 1'b0; frame_mode = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_dout_valid", 64'(if0.dout_valid), 64'd0);
        check("rst_dout", 64'(if0.dout), 64'd0);
        check("rst_shift", 64'(if0.shift_value), 64'd0);
        check("rst_eof", 64'(if0.dout_eof), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_dout_valid", 64'(if0.dout_valid), 64'd0);

        // Per-sample vectors on the default instance.
        for (int i = 0; i < 12; i++) begin
            send(tbl[i].din);
            wait_valid(0, lat);
            check($sformatf("vec%0d_latency", i), 64'(lat + 1), 64'd4);
            check($sformatf("vec%0d_dout", i), 64'(if0.dout), 64'(tbl[i].dout));
            check($sformatf("vec%0d_shift", i), 64'(if0.shift_value), 64'(tbl[i].sh));
            check($sformatf("vec%0d_eof", i), 64'(if0.dout_eof), 64'd1);
            @(negedge clk);
            check($sformatf("vec%0d_single", i), 64'(if0.dout_valid), 64'd0);
        end

        // MIN_SHIFT clamp beyond true headroom.
        send(32'h40000001);
        wait_valid(1, lat);
        check("min_latency", 64'(lat + 1), 64'd4);
        check("min_dout", 64'(if1.dout), SAT ? 64'h7FFF0004 : 64'h00000004);
        check("min_shift", 64'(if1.shift_value), 64'd2);
        @(negedge clk);

        // Random stream with backpressure, per-sample then per-frame.
        run_random(504, 1'b0);
        run_random(504, 1'b1);

        // Frame of four on the FRAME_LEN=4 instance: shift frozen from beat 0.
        frame_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = f_din[i]; din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
        wait_valid(2, lat);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("frm%0d_valid", i), 64'(if2.dout_valid), 64'd1);
            check($sformatf("frm%0d_dout", i), 64'(if2.dout), 64'(f_dout[i]));
            check($sformatf("frm%0d_shift", i), 64'(if2.shift_value), 64'd9);
            check($sformatf("frm%0d_eof", i), 64'(if2.dout_eof), 64'(f_eof[i]));
            @(negedge clk);
        end

        // Reset with three beats in flight under a stalled output.
        dout_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din = 32'h00100000; din_valid = 1'b1;
            @(negedge clk);
        end
        din_valid = 1'b0;
        @(negedge clk);
        check("inflight_valid", 64'(if2.dout_valid), 64'd1);
        check("inflight_ready", 64'(if2.din_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", 64'(if2.dout_valid), 64'd0);
        check("rst_mid_dout", 64'(if2.dout), 64'd0);
        check("rst_mid_shift", 64'(if2.shift_value), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        dout_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("post_rst_idle%0d", i), 64'(if2.dout_valid), 64'd0);
        end
        send(32'h40000000);
        wait_valid(2, lat);
        check("post_rst_latency", 64'(lat + 1), 64'd4);
        check("post_rst_dout", 64'(if2.dout), 64'h40000000);
        check("post_rst_shift", 64'(if2.shift_value), 64'd0);
        check("post_rst_eof", 64'(if2.dout_eof), 64'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
